// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default sizing and Gray/binary conversion helpers.
package fifo_pkg;

  localparam int unsigned ADDR_SIZE_DEF    = 4;
  localparam int unsigned DEPTH            = 1 << ADDR_SIZE_DEF;
  localparam int unsigned AFULL_MARGIN_DEF = 2;

  // Conversions work on 32-bit zero-extended values, so any width up to 32 is
  // handled correctly; callers cast the result back to their pointer width.
  localparam int unsigned CONV_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB downward.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b = g;
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter, shared by both FIFO pointer domains.
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Widen into the shared helper and trim back to the pointer width.
  always_comb begin
    bin = W'(gray2bin(CONV_W'(gray)));
  end

endmodule

// File: rtl/w_ptr_full_level.sv
// Write-side pointer, full, almost-full, fill level and sticky overflow for an async FIFO.
module w_ptr_full_level
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE    = ADDR_SIZE_DEF,
  parameter int unsigned AFULL_MARGIN = AFULL_MARGIN_DEF
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  input  logic [ADDR_SIZE:0]   w_syn_r_gray,
  input  logic                 w_inc,
  input  logic                 w_clr_ovf,
  output logic                 w_en,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic [ADDR_SIZE:0]   w_gray,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic [ADDR_SIZE:0]   w_level,
  output logic                 w_overflow
);

  localparam int unsigned PTR_W   = ADDR_SIZE + 1;
  localparam int unsigned W_DEPTH = 1 << ADDR_SIZE;
  localparam int unsigned AF_THR  = W_DEPTH - AFULL_MARGIN;

  // Reject margins that would make almost-full constant.
  if (AFULL_MARGIN < 1 || AFULL_MARGIN > W_DEPTH - 1) begin : g_bad_margin
    $error("w_ptr_full_level: AFULL_MARGIN must be in 1..DEPTH-1");
  end

  logic [PTR_W-1:0] w_bin;
  logic [PTR_W-1:0] w_bin_next;
  logic [PTR_W-1:0] w_gray_next;
  logic [PTR_W-1:0] r_bin_syn;
  logic [PTR_W-1:0] level_val;
  logic             full_val;
  logic             afull_val;
  logic             ovf_next;

  // Synchronised read pointer back to binary for the level subtraction.
  gray_to_bin #(.W(PTR_W)) u_r_g2b (
    .gray (w_syn_r_gray),
    .bin  (r_bin_syn)
  );

  // A write is accepted only when not already full.
  assign w_en   = w_inc & ~w_full;
  assign w_addr = w_bin[ADDR_SIZE-1:0];

  // Next pointer and flag values; full/level look at the post-write pointer
  // so the flag rises on the edge that accepts the last free slot.
  always_comb begin
    w_bin_next  = '0;
    w_gray_next = '0;
    level_val   = '0;
    full_val    = 1'b0;
    afull_val   = 1'b0;
    ovf_next    = w_overflow;

    w_bin_next  = w_bin + PTR_W'(w_en);
    w_gray_next = PTR_W'(bin2gray(CONV_W'(w_bin_next)));
    full_val    = (w_gray_next == {~w_syn_r_gray[ADDR_SIZE:ADDR_SIZE-1],
                                   w_syn_r_gray[ADDR_SIZE-2:0]});
    level_val   = w_bin_next - r_bin_syn;
    afull_val   = (level_val >= PTR_W'(AF_THR));

    // Set wins over clear when both happen in one cycle.
    if (w_inc && w_full) begin
      ovf_next = 1'b1;
    end else if (w_clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_bin         <= '0;
      w_gray        <= '0;
      w_full        <= 1'b0;
      w_almost_full <= 1'b0;
      w_level       <= '0;
      w_overflow    <= 1'b0;
    end else begin
      w_bin         <= w_bin_next;
      w_gray        <= w_gray_next;
      w_full        <= full_val;
      w_almost_full <= afull_val;
      w_level       <= level_val;
      w_overflow    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_w_ptr_full_level.sv
// Directed and random bench for the write-side pointer/full/level block.
module tb_w_ptr_full_level;

  localparam int unsigned AW    = 4;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEP   = 1 << AW;
  localparam int unsigned AFTHR = DEP - 2;

  typedef struct {
    logic [PW-1:0] gray;
    logic [AW-1:0] addr;
    logic          full;
    logic          afull;
    logic [PW-1:0] level;
    logic          ovf;
  } exp_t;

  logic          w_clk;
  logic          w_rst_n;
  logic [PW-1:0] w_syn_r_gray;
  logic          w_inc;
  logic          w_clr_ovf;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [PW-1:0] w_gray;
  logic          w_full;
  logic          w_almost_full;
  logic [PW-1:0] w_level;
  logic          w_overflow;

  int vectors    = 0;
  int miscompares = 0;

  exp_t sb[$];

  // Reference model state (accepted writes, flags).
  logic [PW-1:0] m_bin;
  logic [PW-1:0] m_gray;
  logic          m_full;
  logic          m_ovf;

  w_ptr_full_level #(.ADDR_SIZE(AW), .AFULL_MARGIN(2)) dut (
    .w_clk         (w_clk),
    .w_rst_n       (w_rst_n),
    .w_syn_r_gray  (w_syn_r_gray),
    .w_inc         (w_inc),
    .w_clr_ovf     (w_clr_ovf),
    .w_en          (w_en),
    .w_addr        (w_addr),
    .w_gray        (w_gray),
    .w_full        (w_full),
    .w_almost_full (w_almost_full),
    .w_level       (w_level),
    .w_overflow    (w_overflow)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Asynchronous reset with no clock edge in between; outputs must clear at once.
  task automatic do_reset();
    @(negedge w_clk);
    w_inc = 1'b0; w_clr_ovf = 1'b0; w_syn_r_gray = '0;
    #1 w_rst_n = 1'b0;
    #1;
    chk("rst_gray",  32'(w_gray), 32'd0);
    chk("rst_addr",  32'(w_addr), 32'd0);
    chk("rst_full",  32'(w_full), 32'd0);
    chk("rst_afull", 32'(w_almost_full), 32'd0);
    chk("rst_level", 32'(w_level), 32'd0);
    chk("rst_ovf",   32'(w_overflow), 32'd0);
    chk("rst_en",    32'(w_en), 32'd0);
    m_bin = '0; m_gray = '0; m_full = 1'b0; m_ovf = 1'b0;
    sb.delete();
    @(negedge w_clk);
    w_rst_n = 1'b1;
  endtask

  // One clock of stimulus; expected outputs go into the scoreboard and are
  // checked after the edge.
  task automatic step(input logic inc, input logic clr, input logic [PW-1:0] syn);
    exp_t          e;
    exp_t          got;
    logic          en;
    logic [PW-1:0] bin_n;
    logic [PW-1:0] lvl;
    logic [PW-1:0] old_gray;
    @(negedge w_clk);
    w_inc = inc; w_clr_ovf = clr; w_syn_r_gray = syn;
    #1;
    en = inc & ~m_full;
    chk("w_en", 32'(w_en), 32'(en));
    bin_n   = m_bin + PW'(en);
    lvl     = bin_n - g2b(syn);
    e.gray  = b2g(bin_n);
    e.addr  = bin_n[AW-1:0];
    e.full  = (lvl == PW'(DEP));
    e.afull = (lvl >= PW'(AFTHR));
    e.level = lvl;
    e.ovf   = (inc & m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    sb.push_back(e);
    old_gray = m_gray;
    m_bin  = bin_n;
    m_gray = e.gray;
    m_full = e.full;
    m_ovf  = e.ovf;
    @(posedge w_clk);
    #1;
    got = sb.pop_front();
    chk("gray",  32'(w_gray), 32'(got.gray));
    chk("addr",  32'(w_addr), 32'(got.addr));
    chk("full",  32'(w_full), 32'(got.full));
    chk("afull", 32'(w_almost_full), 32'(got.afull));
    chk("level", 32'(w_level), 32'(got.level));
    chk("ovf",   32'(w_overflow), 32'(got.ovf));
    chk("gray_onebit", 32'($countones(w_gray ^ old_gray)), 32'(en));
  endtask

  initial begin
    logic [PW-1:0] r_cnt;
    logic          inc;
    w_rst_n = 1'b1; w_inc = 1'b0; w_clr_ovf = 1'b0; w_syn_r_gray = '0;
    m_bin = '0; m_gray = '0; m_full = 1'b0; m_ovf = 1'b0;
    #2 w_rst_n = 1'b0;
    #1;
    chk("init_gray",  32'(w_gray), 32'd0);
    chk("init_full",  32'(w_full), 32'd0);
    chk("init_level", 32'(w_level), 32'd0);
    chk("init_ovf",   32'(w_overflow), 32'd0);
    @(negedge w_clk);
    w_rst_n = 1'b1;

    // Reset mid-stream, then three writes.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    chk("rst3_addr", 32'(w_addr), 32'd3);
    chk("rst3_gray", 32'(w_gray), 32'b00010);

    // Fill to full with the read pointer parked at zero.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, '0);
      if (i == 14) begin
        chk("fill14_level", 32'(w_level), 32'd14);
        chk("fill14_afull", 32'(w_almost_full), 32'd1);
      end
    end
    chk("fill16_full",  32'(w_full), 32'd1);
    chk("fill16_level", 32'(w_level), 32'd16);
    chk("fill16_gray",  32'(w_gray), 32'b11000);
    chk("fill16_addr",  32'(w_addr), 32'd0);

    // Overflow: set, set-wins-over-clear, clear.
    step(1'b1, 1'b0, '0);
    chk("ovf_gray", 32'(w_gray), 32'b11000);
    chk("ovf_set",  32'(w_overflow), 32'd1);
    step(1'b1, 1'b1, '0);
    chk("ovf_setwins", 32'(w_overflow), 32'd1);
    step(1'b0, 1'b1, '0);
    chk("ovf_clr", 32'(w_overflow), 32'd0);

    // Freed slots become visible through the synchronised read pointer.
    step(1'b0, 1'b0, 5'b00110);
    chk("drain_full",  32'(w_full), 32'd0);
    chk("drain_level", 32'(w_level), 32'd12);
    chk("drain_afull", 32'(w_almost_full), 32'd0);

    // Wrap: read pointer trails two writes behind for 40 writes.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b0, (k <= 2) ? '0 : b2g(PW'(k - 2)));
      chk("wrap_nofull", 32'(w_full), 32'd0);
      if (k >= 2) chk("wrap_level", 32'(w_level), 32'd2);
      if (k == 32) chk("wrap_gray0", 32'(w_gray), 32'd0);
    end

    // Random writes with legal one-step read pointer advances.
    do_reset();
    r_cnt = '0;
    for (int c = 0; c < 400; c++) begin
      inc = ($urandom_range(0, 2) != 0);
      if (r_cnt != m_bin && $urandom_range(0, 2) == 0) r_cnt = r_cnt + 1'b1;
      step(inc, ($urandom_range(0, 7) == 0), b2g(r_cnt));
      if (w_full) begin
        chk("inv_full_level", 32'(w_level), 32'(DEP));
        chk("inv_full_afull", 32'(w_almost_full), 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
